// File: rtl/seq_nonrestoring_divider.sv
// Multi-cycle non-restoring divider: one quotient bit per clock,
// signed/unsigned per request, divide-by-zero detection.
module seq_nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_div_zero;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_d_ext;
    logic [WIDTH:0]   w_a_step;
    logic [WIDTH:0]   w_a_fix;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_div_zero = (divisor == '0);
    assign w_dvd_neg  = signed_mode & dividend[WIDTH-1];
    assign w_dvs_neg  = signed_mode & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;

    // Accumulator may wrap on the shift; the add/sub brings it back in range.
    assign w_d_ext    = {1'b0, r_d};
    assign w_shift    = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_a_step   = r_a[WIDTH] ? (w_shift + w_d_ext)
                                   : (w_shift - w_d_ext);
    assign w_a_fix    = r_a[WIDTH] ? (r_a + w_d_ext) : r_a;
    assign w_quot_fix = r_q_neg ? -r_q : r_q;
    assign w_rem_fix  = r_r_neg ? -w_a_fix[WIDTH-1:0]
                                : w_a_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_div_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_dbz  <= 1'b0;
                        r_dz   <= w_div_zero;
                        r_a    <= '0;
                        r_cnt  <= CW'(WIDTH);
                        r_d    <= w_dvs_mag;
                        // On /0 the raw dividend rides in Q to the remainder.
                        if (w_div_zero) begin
                            r_q     <= dividend;
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                        end else begin
                            r_q     <= w_dvd_mag;
                            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
                            r_r_neg <= w_dvd_neg;
                        end
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_step;
                    r_q   <= {r_q[WIDTH-2:0], ~w_a_step[WIDTH]};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_a    <= w_a_fix;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_dbz  <= r_dz;
                    if (r_dz) begin
                        r_quot <= '1;
                        r_rem  <= r_q;
                    end else begin
                        r_quot <= w_quot_fix;
                        r_rem  <= w_rem_fix;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Bench for seq_nonrestoring_divider: arithmetic model plus
// hand-computed directed vectors.
module tb_seq_nonrestoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_nonrestoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           c0;
    } req_t;

    req_t         pend[$];
    int           cyc;
    int           n_pass;
    int           n_total;
    bit           have_last;
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_dz;

    // Result = {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [2*W:0] model(bit sm, logic [W-1:0] a,
                                           logic [W-1:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (sm) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, q[W-1:0], r[W-1:0]};
    endfunction

    function automatic int lat(logic [W-1:0] b);
        return (b == '0) ? 1 : W + 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Compare process: result, latency and hold checks every cycle.
    always @(negedge clk) begin
        logic [2*W:0] m;
        req_t         h;
        if (rst_n) begin
            if (done) begin
                if (pend.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    h = pend.pop_front();
                    m = model(h.sm, h.a, h.b);
                    chk("latency", cyc - h.c0, lat(h.b));
                    chk("quotient", quotient, m[2*W-1:W]);
                    chk("remainder", remainder, m[W-1:0]);
                    chk("div_by_zero", div_by_zero, m[2*W]);
                    last_q    = m[2*W-1:W];
                    last_r    = m[W-1:0];
                    last_dz   = m[2*W];
                    have_last = 1'b1;
                end
            end else begin
                if (pend.size() > 0 &&
                    cyc >= pend[0].c0 + lat(pend[0].b)) begin
                    chk("done_timeout", 0, 1);
                    void'(pend.pop_front());
                end
                if (!busy && have_last) begin
                    chk("hold_q", quotient, last_q);
                    chk("hold_r", remainder, last_r);
                    chk("hold_dz", div_by_zero, last_dz);
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the start edge.
    task automatic issue(bit sm, logic [W-1:0] a, logic [W-1:0] b,
                         bit accept);
        req_t r;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        if (accept) begin
            r.sm = sm;
            r.a  = a;
            r.b  = b;
            r.c0 = cyc + 1;
            pend.push_back(r);
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        dividend    = W'($urandom);
        divisor     = W'($urandom);
        signed_mode = 1'($urandom);
        if (accept) begin
            chk("busy_after_start", busy, 1);
            chk("dbz_cleared", div_by_zero, 0);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (pend.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (pend.size() != 0) begin
            chk("wait_idle_timeout", pend.size(), 0);
            pend.delete();
        end
    endtask

    task automatic run(bit sm, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] eq, logic [W-1:0] er, bit edz);
        logic [2*W:0] m;
        issue(sm, a, b, 1'b1);
        wait_idle();
        m = model(sm, a, b);
        chk("model_q", m[2*W-1:W], eq);
        chk("model_r", m[W-1:0], er);
        chk("lit_q", quotient, eq);
        chk("lit_r", remainder, er);
        chk("lit_dz", div_by_zero, edz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc         = 0;
        n_pass      = 0;
        n_total     = 0;
        have_last   = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(0, 8'd100, 8'd7,  8'h0E, 8'h02, 0);
        run(1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 0);
        run(1, 8'h64,  8'hF9, 8'hF2, 8'h02, 0);
        run(1, 8'h9C,  8'hF9, 8'h0E, 8'hFE, 0);
        run(0, 8'h37,  8'h00, 8'hFF, 8'h37, 1);
        run(0, 8'd100, 8'd7,  8'h0E, 8'h02, 0);
        run(1, 8'h37,  8'h00, 8'hFF, 8'h37, 1);
        run(1, 8'h80,  8'hFF, 8'h80, 8'h00, 0);
        run(0, 8'd255, 8'd1,  8'hFF, 8'h00, 0);
        run(0, 8'd5,   8'd9,  8'h00, 8'h05, 0);
        run(0, 8'd255, 8'd255, 8'h01, 8'h00, 0);
        run(1, 8'h80,  8'h01, 8'h80, 8'h00, 0);
        run(1, 8'h07,  8'hFE, 8'hFD, 8'h01, 0);

        // Ignored start while busy, then start in the done cycle.
        issue(0, 8'd200, 8'd3, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        issue(0, 8'd10, 8'd2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        chk("b2b_first_done", done, 1);
        chk("b2b_first_q", quotient, 8'd66);
        chk("b2b_first_r", remainder, 8'd2);
        issue(0, 8'd50, 8'd5, 1'b1);
        wait_idle();
        chk("b2b_second_q", quotient, 8'd10);
        chk("b2b_second_r", remainder, 8'd0);

        // Asynchronous reset in the middle of CALC.
        issue(0, 8'd200, 8'd3, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        pend.delete();
        have_last = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", done, 0);
        run(0, 8'd200, 8'd3, 8'd66, 8'd2, 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_nonrestoring_divider.md
Name: seq_nonrestoring_divider

Overview:
- Parametrised, multi-cycle non-restoring integer divider. Computes quotient and remainder of dividend / divisor, one quotient bit per clock, using a single shared (WIDTH+1)-bit add/sub datapath.
- Adds a start/busy/done handshake, signed or unsigned operation selected per request, and divide-by-zero detection.
- Serves as the generalised, clocked successor of the team's 4-bit combinational non-restoring divider, for use in datapaths that can tolerate WIDTH+1 cycles of latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2)

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  reset; asynchronous assert, active-low
- start  input  1  request; sampled only when busy=0
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
- dividend  input  WIDTH  dividend; captured with start
- divisor  input  WIDTH  divisor; captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse; results valid
- quotient  output  WIDTH  quotient, registered
- remainder  output  WIDTH  remainder, registered
- div_by_zero  output  1  set with done when the captured divisor was 0

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; internal accumulator, counter and captured operands = 0.
- Reset asserted mid-operation aborts the operation. No done is produced for the aborted request.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Capture operands and mode; busy=1; clear done and div_by_zero.
  - If divisor==0 -> FIX. Otherwise -> CALC with counter=WIDTH.
  - Signed mode: take magnitudes of both operands; record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
- CALC, one edge per quotient bit:
  - Shift {A,Q} left by 1, where A is a (WIDTH+1)-bit signed accumulator.
  - If the old A was >= 0, A = A - D; otherwise A = A + D. D is the zero-extended divisor magnitude.
  - Set Q[0] = ~A[WIDTH] (new sign). Decrement the counter.
  - After WIDTH iterations (edges E1..E_WIDTH) -> FIX.
- FIX, one edge (E_WIDTH+1):
  - If A < 0, A = A + D.
  - Apply signs: quotient = q_neg ? -Q : Q; remainder = r_neg ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - Set done=1, busy=0; -> IDLE.
- Latency: done is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 edges after the start edge. Divide-by-zero case: done after 1 edge (E1).
- Divide by zero: quotient = all ones, remainder = dividend (raw, unsigned interpretation), div_by_zero=1. Applies in both modes.
- Signed rounding: quotient truncates toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
- Signed overflow (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1) (wraps), remainder = 0; no flag.
- done lasts exactly one cycle. quotient, remainder and div_by_zero hold until the next accepted start, which clears div_by_zero.
- start while busy=1 is ignored; the request is not queued.
- start in the same cycle that done=1 is accepted, because state is already IDLE, giving back-to-back operation.
- Operand inputs may change freely after the capture edge without affecting the result.

Test Plan:
- WIDTH=8, unsigned 100/7 -> done exactly 9 edges after the start edge; quotient=14 (0x0E), remainder=2; div_by_zero=0.
- Signed: -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2). Signed 100/-7 -> 0xF2, 0x02. Signed -100/-7 -> 0x0E, 0xFE.
- Unsigned 0x37/0 -> done 1 edge after start; quotient=0xFF, remainder=0x37, div_by_zero=1. The next valid start clears div_by_zero.
- Edge values:
  - signed 0x80/0xFF -> quotient=0x80, remainder=0x00
  - unsigned 255/1 -> 255, 0
  - unsigned 5/9 -> 0, 5
  - unsigned 255/255 -> 1, 0
- Pulse start with new operands 3 cycles after an accepted start -> ignored; the first result is unchanged. Then start asserted in the done cycle -> second operation accepted, its done 9 edges later.
- Drop rst_n mid-CALC -> all outputs 0 immediately (asynchronous); no done pulse. After release, a fresh 200/3 -> 66, 2.
